ps2_key_scanner: RTL
====================

PS2_KEY_SCANNER -- requirements
Module: ps2_key_scanner

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 8, number of tracked keys (1..32).
REQ-002 SHALL have parameter FILTER_LEN, default 8, glitch-filter depth in clk cycles (>=2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 200000, max clk cycles between PS/2 clock falling edges inside a frame.
REQ-004 SHALL have parameter KEYMAP, width 9*NUM_KEYS, where entry i = KEYMAP[9i+8:9i] = {ext, code}; default {1'h1,8'h72, 1'h1,8'h75, 1'h0,8'h2D, 1'h0,8'h29, 1'h0,8'h1D, 1'h0,8'h1B, 1'h0,8'h1C, 1'h0,8'h23} (i7..i0: Down, Up, R, Space, W, S, A, D).
REQ-005 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port ps2_clk  input  1  raw PS/2 clock, asynchronous.
REQ-008 SHALL have port ps2_data  input  1  raw PS/2 data, asynchronous.
REQ-009 SHALL have port keys  output  NUM_KEYS  held-down level per keymap entry.
REQ-010 SHALL have port key_press  output  NUM_KEYS  one-cycle pulse on make of a released key.
REQ-011 SHALL have port key_release  output  NUM_KEYS  one-cycle pulse on break of a held key.
REQ-012 SHALL have port byte_valid  output  1  one-cycle pulse, good byte on byte_data.
REQ-013 SHALL have port byte_data  output  8  last good received byte.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse on framing/parity error or timeout.

Function
REQ-015 SHALL pass ps2_clk and ps2_data each through a 2-flop synchroniser, then a FILTER_LEN shift filter: filtered level goes 1 only when all taps are 1, goes 0 only when all are 0, else holds.
REQ-016 SHALL detect a PS/2 clock falling edge as filtered clock 1 in previous cycle, 0 in current; no logic clocked by ps2_clk.
REQ-017 SHALL sample filtered data on each falling edge into an 11-bit frame (start, D0..D7 LSB first, odd parity, stop) with a bit counter 0..10.
REQ-018 Frame check on 11th edge SHALL require start=0, stop=1, XOR(D0..D7, parity)=1.
REQ-019 With 11th edge detected in cycle T, SHALL pulse byte_valid and update byte_data in T+1 on good frame, or pulse frame_err in T+1 on bad frame; counter returns to 0 in T+1.
REQ-020 SHALL run a timeout counter cleared on every falling edge and when bit counter = 0; if it reaches TIMEOUT_CYCLES with bit counter != 0, SHALL reset bit counter to 0, clear prefix state and pulse frame_err for one cycle.
REQ-021 Decoder FSM SHALL have states BASE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0); transitions on good bytes only: BASE-E0->EXT, BASE-F0->BRK, EXT-F0->EXT_BRK, any other byte -> BASE after lookup.
REQ-022 E0 in EXT/BRK/EXT_BRK, or F0 in BRK/EXT_BRK, SHALL move to EXT (for E0) or stay (for F0) without lookup.
REQ-023 On a non-prefix byte b in T+1, in T+2 for every i with KEYMAP entry == {ext, b}: make sets keys[i]=1, break clears keys[i]=0; ext=1 in EXT/EXT_BRK, break in BRK/EXT_BRK.
REQ-024 key_press[i] SHALL pulse only when make and keys[i] was 0 (typematic repeats suppressed); key_release[i] only when break and keys[i] was 1.
REQ-025 Unmapped codes SHALL change no keys and return FSM to BASE.
REQ-026 Duplicate KEYMAP entries SHALL all update together.
REQ-027 A frame_err SHALL return FSM to BASE, leave keys unchanged.

Reset
REQ-028 On rst_n=0, asynchronously: keys, key_press, key_release, byte_valid, frame_err = 0; byte_data = 8'h00; bit counter, timeout counter = 0; FSM = BASE; filter taps and filtered levels = 1 (idle bus).
REQ-029 Reset mid-frame SHALL discard the partial frame; first frame after release decodes normally.

Verification
REQ-030 Frame 1C -> byte_valid 1 cycle, byte_data=8'h1C, keys[1]=1, key_press[1] pulse 1 cycle later.
REQ-031 Frames 1C,1C,F0,1C -> one key_press[1], keys[1] 1 then 0, one key_release[1]; no pulse on repeat.
REQ-032 Frames E0,75 then E0,F0,75 -> keys[6] 1 then 0; plain 75 alone -> keys unchanged.
REQ-033 Frame 23 with parity bit inverted -> frame_err pulse, no byte_valid, keys[0]=0; next good 23 -> keys[0]=1.
REQ-034 Send 5 bits then stall ps2_clk > TIMEOUT_CYCLES -> frame_err pulse; following full frame 29 -> keys[4]=1.
REQ-035 1-cycle glitches on ps2_clk during idle with FILTER_LEN=8 -> no bit sampled, no outputs change.

Source files
------------

// File: rtl/ps2_key_scanner.sv
// ps2_key_scanner
//   Receives PS/2 keyboard frames on raw, asynchronous ps2_clk/ps2_data
//   lines and keeps a held-down level for each entry of a small keymap.
//   Scan code set 2 framing is assumed: optional E0 (extended) prefix,
//   optional F0 (break) prefix, then the key code.
//
//   The PS/2 lines are oversampled on clk. Each line passes through a
//   2-flop synchroniser and a FILTER_LEN-deep agreement filter. Falling
//   edges of the filtered clock shift bits into an 11-bit frame. Good bytes
//   drive a prefix decoder FSM, and the FSM triggers keymap lookups.
//
// Parameters
//   NUM_KEYS       number of tracked keys (1..32)
//   FILTER_LEN     glitch filter depth in clk cycles (>= 2)
//   TIMEOUT_CYCLES max clk cycles allowed between PS/2 clock falls in a frame
//   KEYMAP         entry i = KEYMAP[9i+8:9i] = {ext, code}
//
// Ports
//   clk          system clock, all logic on its rising edge
//   rst_n        asynchronous active-low reset
//   ps2_clk      raw PS/2 clock (asynchronous)
//   ps2_data     raw PS/2 data (asynchronous)
//   keys         held-down level per keymap entry
//   key_press    one-cycle pulse when a released key is made
//   key_release  one-cycle pulse when a held key is broken
//   byte_valid   one-cycle pulse: a good byte is on byte_data
//   byte_data    last good received byte
//   frame_err    one-cycle pulse on framing/parity error or timeout
//   dbg_state    decoder FSM state (BASE=0, EXT=1, BRK=2, EXT_BRK=3)
//
// Handshake: none of the outputs take backpressure. byte_valid, key_press,
// key_release and frame_err are single-cycle strobes that are valid only
// in the cycle they are high. A consumer that misses a strobe loses it.
// keys and byte_data are levels that hold until the next update.
module ps2_key_scanner #(
  parameter int NUM_KEYS       = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter logic [9*NUM_KEYS-1:0] KEYMAP = {
    1'h1, 8'h72,  // 7 Down
    1'h1, 8'h75,  // 6 Up
    1'h0, 8'h2D,  // 5 R
    1'h0, 8'h29,  // 4 Space
    1'h0, 8'h1D,  // 3 W
    1'h0, 8'h1B,  // 2 S
    1'h0, 8'h1C,  // 1 A
    1'h0, 8'h23   // 0 D
  }
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [NUM_KEYS-1:0] keys,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                byte_valid,
  output logic [7:0]          byte_data,
  output logic                frame_err,
  output logic [1:0]          dbg_state
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  // --------------------------------------------------------------------
  // Synchronisers and glitch filters. Everything resets to 1 because the
  // PS/2 bus idles high.
  // --------------------------------------------------------------------
  logic [1:0]            clk_sync;
  logic [1:0]            data_sync;
  logic [FILTER_LEN-1:0] clk_taps;
  logic [FILTER_LEN-1:0] data_taps;
  logic                  clk_filt;
  logic                  data_filt;
  logic                  clk_filt_d;
  logic                  ps2_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_taps  <= '1;
      data_taps <= '1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_taps  <= {clk_taps[FILTER_LEN-2:0], clk_sync[1]};
      data_taps <= {data_taps[FILTER_LEN-2:0], data_sync[1]};
    end
  end

  // A filtered level changes only when every tap agrees. Anything shorter
  // than FILTER_LEN cycles leaves the previous level in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt   <= 1'b1;
      data_filt  <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      if (&clk_taps) begin
        clk_filt <= 1'b1;
      end else if (~|clk_taps) begin
        clk_filt <= 1'b0;
      end
      if (&data_taps) begin
        data_filt <= 1'b1;
      end else if (~|data_taps) begin
        data_filt <= 1'b0;
      end
      clk_filt_d <= clk_filt;
    end
  end

  assign ps2_fall = clk_filt_d & ~clk_filt;

  // --------------------------------------------------------------------
  // Frame receiver.
  // frame_sr is shifted right on each of the first ten edges. After the
  // tenth edge it holds {parity, D7..D0, start}. The stop bit is not
  // stored: it is the live filtered data level on the eleventh edge.
  // --------------------------------------------------------------------
  logic [3:0]      bit_cnt;
  logic [9:0]      frame_sr;
  logic [TO_W-1:0] to_cnt;
  logic            frame_ok;
  logic            timeout_hit;

  assign frame_ok = (frame_sr[0] == 1'b0) && data_filt && (^frame_sr[9:1]);

  assign timeout_hit = (bit_cnt != 4'd0) && (to_cnt == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= 4'd0;
      frame_sr   <= '0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (ps2_fall) begin
        to_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (frame_ok) begin
            byte_valid <= 1'b1;
            byte_data  <= frame_sr[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          frame_sr <= {data_filt, frame_sr[9:1]};
          bit_cnt  <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt == 4'd0) begin
        to_cnt <= '0;
      end else if (timeout_hit) begin
        // A stalled frame is dropped. The frame_err pulse also sends the
        // decoder back to BASE, so any pending prefix is cleared.
        bit_cnt   <= 4'd0;
        to_cnt    <= '0;
        frame_err <= 1'b1;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------
  // Prefix decoder FSM. It advances only on byte_valid or frame_err.
  // --------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_BASE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  dec_state_t state_q;
  dec_state_t state_d;
  logic       do_lookup;
  logic       lk_ext;
  logic       lk_brk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BASE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    do_lookup = 1'b0;
    lk_ext    = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    lk_brk    = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    if (frame_err) begin
      state_d = ST_BASE;
    end else if (byte_valid) begin
      if (byte_data == CODE_EXT) begin
        // A fresh E0 always restarts an extended sequence. A stray F0
        // seen before it is dropped.
        state_d = ST_EXT;
      end else if (byte_data == CODE_BRK) begin
        case (state_q)
          ST_BASE: state_d = ST_BRK;
          ST_EXT:  state_d = ST_EXT_BRK;
          default: state_d = state_q;
        endcase
      end else begin
        do_lookup = 1'b1;
        state_d   = ST_BASE;
      end
    end
  end

  assign dbg_state = state_q;

  // --------------------------------------------------------------------
  // Keymap lookup. Every matching entry is updated, so duplicate entries
  // move together.
  // --------------------------------------------------------------------
  logic [NUM_KEYS-1:0] match;
  logic [NUM_KEYS-1:0] keys_d;
  logic [NUM_KEYS-1:0] press_d;
  logic [NUM_KEYS-1:0] release_d;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      match[i] = (KEYMAP[9*i +: 9] == {lk_ext, byte_data});
    end
  end

  always_comb begin
    keys_d    = keys;
    press_d   = '0;
    release_d = '0;
    if (do_lookup) begin
      if (lk_brk) begin
        release_d = match & keys;
        keys_d    = keys & ~match;
      end else begin
        // Typematic repeats re-make a held key. Only the first make pulses.
        press_d = match & ~keys;
        keys_d  = keys | match;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys        <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      keys        <= keys_d;
      key_press   <= press_d;
      key_release <= release_d;
    end
  end

endmodule
